cic_comb_decimator: RTL and testbench

- Comb/decimation stage that undoes the running-sum integrator upstream.
- Takes the integrator's 21-bit wrapped accumulator value and keeps every R-th clock-enabled sample.
- Outputs the M-deep first difference of the kept samples, narrowed to OUT_W bits, with a one-cycle valid strobe.
- Integrator plus this block form a one-stage CIC decimator feeding the downstream 13-bit sample path.

---
 rtl/cic_pkg.sv | 21 ++
 rtl/comb_delay_line.sv | 35 +++
 rtl/cic_comb_decimator.sv | 94 +++++++++
 tb/tb_cic_comb_decimator.sv | 135 +++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared defaults, derived widths and sample types for the single-stage CIC comb/decimator.
// Optional build macro: CIC_COMB_ROUND_EN (round-half-up narrowing with positive saturation).
package cic_pkg;

  localparam int CIC_IN_W  = 21;
  localparam int CIC_OUT_W = 13;
  localparam int CIC_R     = 8;
  localparam int CIC_M     = 1;

  localparam int CIC_SHIFT = CIC_IN_W - CIC_OUT_W;

  function automatic int ph_width(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

  localparam int CIC_PH_W = ph_width(CIC_R);

  typedef logic signed [CIC_IN_W-1:0]  in_t;
  typedef logic signed [CIC_OUT_W-1:0] out_t;

endpackage

// File: rtl/comb_delay_line.sv
// M-deep history of decimated samples; shifts on en, synchronous active-high reset.
module comb_delay_line #(
  parameter int W     = 21,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] tail
);

  logic [W-1:0] hist_q [DEPTH];
  logic [W-1:0] hist_d [DEPTH];

  always_comb begin
    hist_d = hist_q;
    if (en) begin
      hist_d[0] = d;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        hist_d[k] = hist_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (rst) hist_q[k] <= '0;
      else     hist_q[k] <= hist_d[k];
    end
  end

  assign tail = hist_q[DEPTH-1];

endmodule

// File: rtl/cic_comb_decimator.sv
// Comb + decimate-by-R stage following the CIC integrator; y is the M-deep difference, narrowed.
// Build macro CIC_COMB_ROUND_EN selects round-half-up narrowing with positive saturation.
module cic_comb_decimator
  import cic_pkg::*;
#(
  parameter int IN_W  = CIC_IN_W,
  parameter int OUT_W = CIC_OUT_W,
  parameter int R     = CIC_R,
  parameter int M     = CIC_M
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic signed [IN_W-1:0]  x,
  output logic signed [OUT_W-1:0] y,
  output logic                    y_valid
);

  localparam int SHIFT = IN_W - OUT_W;
  localparam int PH_W  = ph_width(R);

  logic [PH_W-1:0]         phase_q, phase_d;
  logic signed [OUT_W-1:0] y_q, y_d;
  logic                    y_valid_q, y_valid_d;
  logic                    decim;
  logic [IN_W-1:0]         hist_tail;
  logic signed [IN_W-1:0]  diff;
  logic signed [OUT_W-1:0] narrow;

  assign decim = ce && (phase_q == PH_W'(R - 1));

  comb_delay_line #(
    .W     (IN_W),
    .DEPTH (M)
  ) u_hist (
    .clk  (clk),
    .rst  (rst),
    .en   (decim),
    .d    (x),
    .tail (hist_tail)
  );

  // Modulo-2^IN_W difference: integrator wrap cancels as long as the true comb output fits.
  assign diff = x - $signed(hist_tail);

  if (SHIFT == 0) begin : g_pass
    assign narrow = diff;
  end else begin : g_narrow
`ifdef CIC_COMB_ROUND_EN
    localparam logic [IN_W:0] HALF = (IN_W + 1)'(1) << (SHIFT - 1);
    logic signed [IN_W:0]  t;
    logic signed [OUT_W:0] q;
    logic                  unused_lsbs;
    assign t           = {diff[IN_W-1], diff} + HALF;
    assign q           = t[IN_W:SHIFT];
    assign unused_lsbs = ^t[SHIFT-1:0];
    // Adding +half can only overflow upward, so only the positive rail is needed.
    assign narrow = (q[OUT_W] != q[OUT_W-1]) ? {1'b0, {(OUT_W-1){1'b1}}} : q[OUT_W-1:0];
`else
    logic unused_lsbs;
    assign unused_lsbs = ^diff[SHIFT-1:0];
    assign narrow      = diff[IN_W-1:SHIFT];
`endif
  end

  always_comb begin
    phase_d   = phase_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    if (ce) begin
      phase_d = decim ? '0 : phase_q + PH_W'(1);
    end
    if (decim) begin
      y_d       = narrow;
      y_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_cic_comb_decimator.sv
// Directed bench for cic_comb_decimator: M=1 and M=2 instances share one stimulus stream.
// Expected values are hand-computed; CIC_COMB_ROUND_EN selects the rounding-build column.
module tb_cic_comb_decimator;
  import cic_pkg::*;

`ifdef CIC_COMB_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, ce;
  in_t  x;
  out_t y1, y2;
  logic y_valid1, y_valid2;

  int n_vec = 0;
  int n_bad = 0;
  int ph    = 0;
  int ey1   = 0;
  int ey2   = 0;
  int exp1[$];
  int exp2[$];

  always #5 clk = ~clk;

  cic_comb_decimator #(.IN_W(21), .OUT_W(13), .R(8), .M(1)) dut_m1 (
    .clk(clk), .rst(rst), .ce(ce), .x(x), .y(y1), .y_valid(y_valid1)
  );

  cic_comb_decimator #(.IN_W(21), .OUT_W(13), .R(8), .M(2)) dut_m2 (
    .clk(clk), .rst(rst), .ce(ce), .x(x), .y(y2), .y_valid(y_valid2)
  );

  task automatic chk(input string tag, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // One clock: apply inputs, advance the bench's phase view, then check both outputs.
  task automatic tick(input logic r, input logic c, input int xv);
    logic evt;
    rst = r;
    ce  = c;
    x   = xv[20:0];
    evt = !r && c && (ph == 7);
    if (r) begin
      ph  = 0;
      ey1 = 0;
      ey2 = 0;
    end else if (c) begin
      ph = (ph == 7) ? 0 : ph + 1;
    end
    if (evt) begin
      ey1 = (exp1.size() > 0) ? exp1.pop_front() : -99999;
      ey2 = (exp2.size() > 0) ? exp2.pop_front() : -99999;
    end
    @(posedge clk);
    #1;
    chk("y_valid_m1", int'(y_valid1), int'(evt));
    chk("y_valid_m2", int'(y_valid2), int'(evt));
    chk("y_m1", int'(y1), ey1);
    chk("y_m2", int'(y2), ey2);
  endtask

  // nsamp ce-qualified samples x = start + step*n; duty<100 inserts random ce=0 gaps.
  task automatic ramp(input int start, input int step, input int nsamp, input int duty);
    for (int n = 0; n < nsamp; n++) begin
      for (int g = 0; g < 10 && duty < 100 && $urandom_range(99) >= duty; g++) begin
        tick(1'b0, 1'b0, int'($urandom));
      end
      tick(1'b0, 1'b1, start + step * n);
    end
  endtask

  initial begin
    rst = 1'b1;
    ce  = 1'b0;
    x   = '0;

    // reset dominates ce; outputs held at zero
    repeat (3) tick(1'b1, 1'b1, 12345);

    // ramp 1000/ce: first 7000/256, then 8000/256 (M=1) and 16000/256 (M=2)
    exp1 = '{27, 31, 31, 31};
    exp2 = '{27, RND ? 59 : 58, RND ? 63 : 62, RND ? 63 : 62};
    ramp(0, 1000, 32, 100);

    // step 1008: steady 8064 = 31.5 LSB
    tick(1'b1, 1'b1, 0);
    exp1 = '{RND ? 28 : 27, RND ? 32 : 31, RND ? 32 : 31};
    exp2 = '{RND ? 28 : 27, 59, 63};
    ramp(0, 1008, 24, 100);

    // same ramp with ~30% ce duty: identical outputs, y held through gaps
    tick(1'b1, 1'b1, 0);
    exp1 = '{27, 31, 31, 31};
    exp2 = '{27, RND ? 59 : 58, RND ? 63 : 62, RND ? 63 : 62};
    ramp(0, 1000, 32, 30);

    // largest positive difference: rounds to 4096 and saturates in rounding build
    tick(1'b1, 1'b1, 0);
    exp1 = '{4095};
    exp2 = '{4095};
    repeat (7) tick(1'b0, 1'b1, 0);
    tick(1'b0, 1'b1, 1048575);

    // accumulator wrap: 1048000 then -1048352 differ by +800 modulo 2^21
    tick(1'b1, 1'b1, 0);
    exp1 = '{RND ? 4094 : 4093, 3};
    exp2 = '{RND ? 4094 : 4093, RND ? -4095 : -4096};
    repeat (7) tick(1'b0, 1'b1, 5);
    tick(1'b0, 1'b1, 1048000);
    repeat (7) tick(1'b0, 1'b1, -7);
    tick(1'b0, 1'b1, -1048352);

    // partial frame to phase 5, reset, then a fresh ramp from zero history
    tick(1'b1, 1'b1, 0);
    ramp(0, 1000, 5, 100);
    tick(1'b1, 1'b1, 12345);
    exp1 = '{27, 31, 31, 31};
    exp2 = '{27, RND ? 59 : 58, RND ? 63 : 62, RND ? 63 : 62};
    ramp(0, 1000, 32, 100);

    repeat (3) tick(1'b0, 1'b0, 999);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
